// File: rtl/int_log_iter.sv
// Sequential floor-logarithm engine: largest k with base**k <= value, one multiply-compare per cycle.
// Optional `INT_LOG_ITER_EXACT_EN adds an `exact` flag reporting base**result == value.
module int_log_iter #(
    parameter int WIDTH = 67,
    parameter int RW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] base,
    input  logic [WIDTH-1:0] value,
    output logic             ready,
    output logic             done,
    output logic [RW-1:0]    result,
    output logic             error
`ifdef INT_LOG_ITER_EXACT_EN
    ,
    output logic             exact
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [WIDTH-1:0]   base_q;
    logic [WIDTH-1:0]   value_q;
    logic [WIDTH-1:0]   acc;
    logic [RW-1:0]      k;
    logic [2*WIDTH-1:0] prod;
    logic               step_ok;
    logic               bad_in;

    // A product is only usable if nothing spilled above WIDTH bits; the low half is never
    // compared on its own once the high half is non-zero, so wrap-around cannot fake a hit.
    function automatic logic fits_below(input logic [2*WIDTH-1:0] p,
                                        input logic [WIDTH-1:0]   lim);
        return (p[2*WIDTH-1:WIDTH] == '0) && (p[WIDTH-1:0] <= lim);
    endfunction

    assign prod    = {{WIDTH{1'b0}}, acc} * {{WIDTH{1'b0}}, base_q};
    assign step_ok = fits_below(prod, value_q);
    assign bad_in  = (base < WIDTH'(2)) || (value == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    state_nxt = bad_in ? DONE : CALC;
                end
            end
            CALC: begin
                if (!step_ok) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operands are captured once at acceptance; later input activity is irrelevant.
    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            base_q  <= base;
            value_q <= value;
        end
    end

    // result/error (and exact) are only written on the edge that enters DONE, so they stay
    // stable from the done pulse until the next request completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            k      <= '0;
            result <= '0;
            error  <= 1'b0;
`ifdef INT_LOG_ITER_EXACT_EN
            exact  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc <= WIDTH'(1);
                        k   <= '0;
                        if (bad_in) begin
                            result <= '0;
                            error  <= 1'b1;
`ifdef INT_LOG_ITER_EXACT_EN
                            exact  <= 1'b0;
`endif
                        end
                    end
                end
                CALC: begin
                    if (step_ok) begin
                        acc <= prod[WIDTH-1:0];
                        k   <= k + RW'(1);
                    end else begin
                        result <= k;
                        error  <= 1'b0;
`ifdef INT_LOG_ITER_EXACT_EN
                        exact  <= (acc == value_q);
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
